// File: rtl/vc_ibuffer_pkg.sv
// Shared constants/helpers for the virtual-channel input buffer.
package vc_ibuf_pkg;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r = r + 1;
    end
    return r;
  endfunction

  // VC index width; a single-VC build still carries a 1-bit index.
  function automatic int unsigned vcw(input int unsigned nvc);
    return (nvc > 1) ? clog2(nvc) : 1;
  endfunction

  // Per-VC occupancy width: must represent 0..DEPTH inclusive.
  function automatic int unsigned cntw(input int unsigned depth);
    return clog2(depth) + 1;
  endfunction

  typedef enum logic {
    LK_OPEN,
    LK_HELD
  } lock_state_e;

endpackage

// File: rtl/vc_ibuffer_if.sv
// Link-side (upstream) and route-side (downstream) handshake bundle.
interface vc_ibuffer_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NUM_VC = 2
);
  import vc_ibuf_pkg::*;

  localparam int unsigned VCW = vcw(NUM_VC);

  logic [WIDTH-1:0]  ldata;
  logic [VCW-1:0]    lvc;
  logic              lvalid;
  logic [NUM_VC-1:0] lrdy;
  logic [WIDTH-1:0]  rdata;
  logic [VCW-1:0]    rvc;
  logic              rvalid;
  logic              rrdy;

  modport master (
    output ldata, lvc, lvalid, rrdy,
    input  lrdy, rdata, rvc, rvalid
  );

  modport slave (
    input  ldata, lvc, lvalid, rrdy,
    output lrdy, rdata, rvc, rvalid
  );

endinterface

// File: rtl/vc_ibuffer_fifo.sv
// Single per-VC synchronous FIFO; DEPTH must be a power of two so pointers wrap naturally.
module vc_fifo
  import vc_ibuf_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
)(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [cntw(DEPTH)-1:0]   o_count
);

  localparam int unsigned PW = clog2(DEPTH);
  localparam int unsigned CW = cntw(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/vc_ibuffer.sv
// Router input buffer: one FIFO per VC, round-robin output arbiter with grant lock.
// Optional occupancy port enabled by defining VC_IBUFFER_OCC_EN.
module vc_ibuffer
  import vc_ibuf_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned NUM_VC = 2
)(
  input  logic clk,
  input  logic rst_n,
  vc_ibuffer_if.slave lnk
`ifdef VC_IBUFFER_OCC_EN
  ,
  output logic [NUM_VC*cntw(DEPTH)-1:0] occ
`endif
);

  localparam int unsigned VCW = vcw(NUM_VC);
  localparam int unsigned CW  = cntw(DEPTH);

  logic [NUM_VC-1:0] w_push;
  logic [NUM_VC-1:0] w_pop;
  logic [NUM_VC-1:0] w_full;
  logic [NUM_VC-1:0] w_empty;
  logic [WIDTH-1:0]  w_head  [NUM_VC];
  logic [CW-1:0]     w_count [NUM_VC];

  logic [VCW-1:0]    r_rr_ptr;
  logic [VCW-1:0]    r_lock_vc;
  logic [VCW-1:0]    r_last_vc;
  logic [WIDTH-1:0]  r_last_data;
  lock_state_e       r_lock_state;
  lock_state_e       w_lock_next;

  logic [VCW-1:0]    w_cand;
  logic [VCW-1:0]    w_scan;
  logic              w_found;
  logic [VCW-1:0]    w_grant;
  logic [VCW-1:0]    w_rr_next;
  logic [WIDTH-1:0]  w_grant_data;
  logic              w_any;
  logic              w_xfer;

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    vc_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push[v]),
      .i_wdata (lnk.ldata),
      .i_pop   (w_pop[v]),
      .o_rdata (w_head[v]),
      .o_full  (w_full[v]),
      .o_empty (w_empty[v]),
      .o_count (w_count[v])
    );
`ifdef VC_IBUFFER_OCC_EN
    assign occ[v*CW +: CW] = w_count[v];
`endif
  end

  assign lnk.lrdy = ~w_full;

  always_comb begin
    w_any = 1'b0;
    for (int unsigned v = 0; v < NUM_VC; v++) begin
      if (w_count[v] != '0) begin
        w_any = 1'b1;
      end
    end
  end

  // First non-empty VC starting at rr_ptr; overridden by the lock while a stalled grant is pending.
  always_comb begin
    w_cand  = '0;
    w_scan  = r_rr_ptr;
    w_found = 1'b0;
    for (int unsigned i = 0; i < NUM_VC; i++) begin
      w_cand = VCW'((32'(r_rr_ptr) + i) % NUM_VC);
      if (!w_found && !w_empty[w_cand]) begin
        w_found = 1'b1;
        w_scan  = w_cand;
      end
    end
    if (r_lock_state == LK_HELD) begin
      w_grant = r_lock_vc;
    end else if (w_found) begin
      w_grant = w_scan;
    end else begin
      w_grant = r_last_vc;
    end
  end

  always_comb begin
    w_grant_data = r_last_data;
    for (int unsigned v = 0; v < NUM_VC; v++) begin
      if (w_grant == VCW'(v)) begin
        w_grant_data = w_head[v];
      end
    end
  end

  assign w_xfer     = w_any && lnk.rrdy;
  assign lnk.rvalid = w_any;
  assign lnk.rvc    = w_grant;
  assign lnk.rdata  = w_any ? w_grant_data : r_last_data;
  assign w_rr_next  = (32'(w_grant) == NUM_VC - 1) ? '0 : w_grant + VCW'(1);

  // Out-of-range lvc matches no FIFO, so such writes vanish without side effects.
  always_comb begin
    w_push = '0;
    w_pop  = '0;
    for (int unsigned v = 0; v < NUM_VC; v++) begin
      w_push[v] = lnk.lvalid && (lnk.lvc == VCW'(v)) && !w_full[v];
      w_pop[v]  = w_xfer && (w_grant == VCW'(v));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock_state <= LK_OPEN;
    end else begin
      r_lock_state <= w_lock_next;
    end
  end

  always_comb begin
    w_lock_next = r_lock_state;
    case (r_lock_state)
      LK_OPEN: begin
        if (w_any && !lnk.rrdy) begin
          w_lock_next = LK_HELD;
        end
      end
      LK_HELD: begin
        if (lnk.rrdy) begin
          w_lock_next = LK_OPEN;
        end
      end
      default: w_lock_next = LK_OPEN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr    <= '0;
      r_lock_vc   <= '0;
      r_last_vc   <= '0;
      r_last_data <= '0;
    end else begin
      if (w_xfer) begin
        r_rr_ptr    <= w_rr_next;
        r_last_vc   <= w_grant;
        r_last_data <= w_grant_data;
      end
      if (r_lock_state == LK_OPEN && w_lock_next == LK_HELD) begin
        r_lock_vc <= w_grant;
      end
    end
  end

endmodule

// File: tb/tb_vc_ibuffer.sv
// Self-checking bench for vc_ibuffer: vector table, directed corner sequences, randomized traffic vs queue model.
module tb_vc_ibuffer;
  import vc_ibuf_pkg::*;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned NUM_VC = 2;
  localparam int unsigned VCW    = vcw(NUM_VC);
  localparam int unsigned CW     = cntw(DEPTH);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  vc_ibuffer_if #(.WIDTH(WIDTH), .NUM_VC(NUM_VC)) lnk();

`ifdef VC_IBUFFER_OCC_EN
  logic [NUM_VC*CW-1:0] occ;
`endif

  vc_ibuffer #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .NUM_VC (NUM_VC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .lnk   (lnk)
`ifdef VC_IBUFFER_OCC_EN
    ,
    .occ   (occ)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: one queue per VC plus round-robin pointer and lock.
  logic [WIDTH-1:0] mq [NUM_VC][$];
  int m_rr;
  int m_lock_vc;
  int m_last_vc;
  bit m_locked;

  typedef struct {
    bit              lv;
    int              lvc;
    logic [WIDTH-1:0] d;
    bit              rr;
    bit              e_valid;
    int              e_vc;
    logic [WIDTH-1:0] e_data;
    bit              chk_data;
    logic [NUM_VC-1:0] e_lrdy;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic bit m_valid();
    for (int v = 0; v < NUM_VC; v++) begin
      if (mq[v].size() != 0) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic int m_grant();
    if (m_locked) return m_lock_vc;
    for (int i = 0; i < NUM_VC; i++) begin
      if (mq[(m_rr + i) % NUM_VC].size() != 0) return (m_rr + i) % NUM_VC;
    end
    return m_last_vc;
  endfunction

  task automatic model_reset();
    for (int v = 0; v < NUM_VC; v++) mq[v].delete();
    m_rr      = 0;
    m_lock_vc = 0;
    m_last_vc = 0;
    m_locked  = 1'b0;
  endtask

  task automatic model_step(input bit lv, input int lvc, input logic [WIDTH-1:0] d, input bit rr);
    bit v;
    int g;
    bit wr_ok;
    v     = m_valid();
    g     = m_grant();
    wr_ok = lv && (lvc < NUM_VC) && (mq[lvc].size() < DEPTH);
    if (v && rr) begin
      void'(mq[g].pop_front());
      m_last_vc = g;
      m_rr      = (g + 1) % NUM_VC;
      m_locked  = 1'b0;
    end else if (v) begin
      m_locked  = 1'b1;
      m_lock_vc = g;
    end
    if (wr_ok) mq[lvc].push_back(d);
  endtask

  task automatic model_check();
    bit v;
    int g;
    logic [NUM_VC-1:0] e_lrdy;
`ifdef VC_IBUFFER_OCC_EN
    logic [NUM_VC*CW-1:0] e_occ;
`endif
    v = m_valid();
    g = m_grant();
    chk("m_rvalid", 32'(lnk.rvalid), 32'(v));
    chk("m_rvc", 32'(lnk.rvc), g);
    if (v) chk("m_rdata", 32'(lnk.rdata), 32'(mq[g][0]));
    for (int i = 0; i < NUM_VC; i++) e_lrdy[i] = (mq[i].size() != DEPTH);
    chk("m_lrdy", 32'(lnk.lrdy), 32'(e_lrdy));
`ifdef VC_IBUFFER_OCC_EN
    for (int i = 0; i < NUM_VC; i++) e_occ[i*CW +: CW] = CW'(mq[i].size());
    chk("m_occ", 32'(occ), 32'(e_occ));
`endif
  endtask

  task automatic cycle(input bit lv, input int lvc, input logic [WIDTH-1:0] d, input bit rr);
    lnk.lvalid = lv;
    lnk.lvc    = VCW'(lvc);
    lnk.ldata  = d;
    lnk.rrdy   = rr;
    @(posedge clk);
    model_step(lv, lvc, d, rr);
    #1;
    model_check();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    lnk.lvalid = 1'b0;
    lnk.lvc    = '0;
    lnk.ldata  = '0;
    lnk.rrdy   = 1'b0;
    model_reset();

    tbl[0]  = '{1'b1, 0, 8'h55, 1'b0, 1'b1, 0, 8'h55, 1'b1, 2'b11};
    tbl[1]  = '{1'b1, 0, 8'h56, 1'b0, 1'b1, 0, 8'h55, 1'b1, 2'b11};
    tbl[2]  = '{1'b1, 0, 8'h57, 1'b0, 1'b1, 0, 8'h55, 1'b1, 2'b11};
    tbl[3]  = '{1'b1, 0, 8'h58, 1'b0, 1'b1, 0, 8'h55, 1'b1, 2'b10};
    tbl[4]  = '{1'b1, 0, 8'h99, 1'b0, 1'b1, 0, 8'h55, 1'b1, 2'b10};
    tbl[5]  = '{1'b1, 1, 8'hA0, 1'b0, 1'b1, 0, 8'h55, 1'b1, 2'b10};
    tbl[6]  = '{1'b0, 0, 8'h00, 1'b1, 1'b1, 1, 8'hA0, 1'b1, 2'b11};
    tbl[7]  = '{1'b0, 0, 8'h00, 1'b1, 1'b1, 0, 8'h56, 1'b1, 2'b11};
    tbl[8]  = '{1'b0, 0, 8'h00, 1'b1, 1'b1, 0, 8'h57, 1'b1, 2'b11};
    tbl[9]  = '{1'b0, 0, 8'h00, 1'b1, 1'b1, 0, 8'h58, 1'b1, 2'b11};
    tbl[10] = '{1'b0, 0, 8'h00, 1'b1, 1'b0, 0, 8'h00, 1'b0, 2'b11};

    // Reset state while rst_n is held low.
    #12;
    chk("rst_rvalid", 32'(lnk.rvalid), 0);
    chk("rst_lrdy", 32'(lnk.lrdy), 32'h3);
    chk("rst_rvc", 32'(lnk.rvc), 0);
    chk("rst_rdata", 32'(lnk.rdata), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_check();

    // Fill VC0, overflow attempt, VC1 write, then interleaved drain.
    for (int i = 0; i < 11; i++) begin
      cycle(tbl[i].lv, tbl[i].lvc, tbl[i].d, tbl[i].rr);
      chk($sformatf("tbl%0d_rvalid", i), 32'(lnk.rvalid), 32'(tbl[i].e_valid));
      chk($sformatf("tbl%0d_rvc", i), 32'(lnk.rvc), tbl[i].e_vc);
      chk($sformatf("tbl%0d_lrdy", i), 32'(lnk.lrdy), 32'(tbl[i].e_lrdy));
      if (tbl[i].chk_data) chk($sformatf("tbl%0d_rdata", i), 32'(lnk.rdata), 32'(tbl[i].e_data));
    end

    // Lock: bring rr_ptr to 0, stall VC1, then make VC0 non-empty.
    cycle(1'b1, 1, 8'h33, 1'b0);
    cycle(1'b0, 0, 8'h00, 1'b1);
    cycle(1'b1, 1, 8'hA0, 1'b0);
    cycle(1'b1, 0, 8'h10, 1'b0);
    chk("lock_rvc0", 32'(lnk.rvc), 1);
    chk("lock_rdata0", 32'(lnk.rdata), 32'hA0);
    cycle(1'b0, 0, 8'h00, 1'b0);
    cycle(1'b0, 0, 8'h00, 1'b0);
    chk("lock_rvc1", 32'(lnk.rvc), 1);
    chk("lock_rdata1", 32'(lnk.rdata), 32'hA0);
    cycle(1'b0, 0, 8'h00, 1'b1);
    chk("lock_after_rvc", 32'(lnk.rvc), 0);
    chk("lock_after_rdata", 32'(lnk.rdata), 32'h10);
    cycle(1'b0, 0, 8'h00, 1'b1);
    chk("lock_drained", 32'(lnk.rvalid), 0);

    // Simultaneous push and pop on the same VC at count 2.
    cycle(1'b1, 0, 8'h21, 1'b0);
    cycle(1'b1, 0, 8'h22, 1'b0);
    cycle(1'b1, 0, 8'h23, 1'b1);
    chk("rw_rdata0", 32'(lnk.rdata), 32'h22);
    chk("rw_lrdy", 32'(lnk.lrdy), 32'h3);
    cycle(1'b0, 0, 8'h00, 1'b1);
    chk("rw_rdata1", 32'(lnk.rdata), 32'h23);
    cycle(1'b0, 0, 8'h00, 1'b1);
    chk("rw_drained", 32'(lnk.rvalid), 0);

    // Asynchronous reset in the middle of traffic.
    cycle(1'b1, 0, 8'h61, 1'b0);
    cycle(1'b1, 1, 8'h62, 1'b0);
    cycle(1'b1, 0, 8'h63, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_rvalid", 32'(lnk.rvalid), 0);
    chk("arst_lrdy", 32'(lnk.lrdy), 32'h3);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_check();
    cycle(1'b1, 1, 8'h77, 1'b0);
    chk("post_rst_rvc", 32'(lnk.rvc), 1);
    chk("post_rst_rdata", 32'(lnk.rdata), 32'h77);
    cycle(1'b0, 0, 8'h00, 1'b1);
    chk("post_rst_empty", 32'(lnk.rvalid), 0);

    // Randomized traffic, alternating stall-heavy and drain-heavy phases.
    for (int i = 0; i < 2000; i++) begin
      int rr_pct;
      rr_pct = ((i / 250) % 2 == 1) ? 85 : 25;
      cycle($urandom_range(0, 99) < 70, $urandom_range(0, NUM_VC - 1),
            WIDTH'($urandom), $urandom_range(0, 99) < rr_pct);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vc_ibuffer.md
Name: vc_ibuffer

Overview:
Router input buffer, successor to the single-channel 4-entry ibuffer. Adds parametrised data width, per-VC depth and virtual-channel count, with one FIFO per VC behind a shared link. Output is a single valid/ready port driven by a round-robin arbiter across non-empty VCs. Sits between the link receiver and the crossbar/route-compute stage.

Parameters:
WIDTH, 8, flit data width in bits
DEPTH, 4, entries per VC FIFO; power of two, >= 2
NUM_VC, 2, number of virtual channels; >= 1
VCW, max(1,clog2(NUM_VC)), localparam, VC index width (not overridable)

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
ldata  in  WIDTH  upstream flit data
lvc  in  VCW  upstream target VC index
lvalid  in  1  upstream flit valid
lrdy  out  NUM_VC  per-VC ready to upstream; bit v = FIFO v not full
rdata  out  WIDTH  head flit of the granted VC
rvc  out  VCW  VC index of rdata
rvalid  out  1  downstream flit valid
rrdy  in  1  downstream ready

Behaviour:
- One clock, clk; reset asynchronous, active-low (rst_n); all flops clear immediately on rst_n low.
- Reset values: all counts/pointers 0, rr_ptr 0, lock clear; rvalid 0, rvc 0, rdata 0, lrdy all 1.
- Write: when lvalid && lrdy[lvc] && lvc < NUM_VC, ldata is stored at wr_ptr[lvc]; wr_ptr wraps modulo DEPTH.
- lvc >= NUM_VC: write silently dropped, no state change.
- lrdy[v] = (count[v] != DEPTH), from registered state only; no combinational path from rrdy or lvalid.
- Read: transfer when rvalid && rrdy; pops the granted VC; rd_ptr wraps modulo DEPTH.
- Latency: a flit written at edge N is visible on rdata/rvalid after edge N (one-cycle minimum), never same-cycle.
- Arbitration: when unlocked, grant = first non-empty VC scanning rr_ptr, rr_ptr+1, ... modulo NUM_VC. rvalid = any count != 0.
- After each pop of VC g, rr_ptr <= (g+1) mod NUM_VC.
- Lock: if rvalid && !rrdy, the grant is latched. rvc/rdata stay stable until the transfer, even if a higher-priority VC becomes non-empty. Lock clears on the transfer.
- Simultaneous write and read on the same VC: count unchanged, both pointers advance. This is legal even when full, because lrdy is already 0 when full, so no write occurs.
- Full VC: lrdy[v] = 0; other VCs unaffected (no head-of-line blocking across VCs).
- Empty all: rvalid 0; rdata/rvc hold last values (don't-care to consumer).
- Reset mid-transfer: in-flight flits discarded; rvalid drops asynchronously.

Optional Feature:
- Macro VC_IBUFFER_OCC_EN.
- Defined: extra output port occ, NUM_VC*(clog2(DEPTH)+1) bits, packing count[v] for each VC (VC0 in LSBs). Registered and reset to 0; intended for credit/congestion monitoring.
- Undefined: port absent; functional behaviour otherwise identical.

Decomposition:
- Shared package/include vc_ibuf_pkg: clog2 constant function, VCW derivation, and the count width constant used by occ.
- One natural sub-module: vc_fifo (WIDTH, DEPTH), a single synchronous FIFO with push/pop/full/empty/count, instantiated NUM_VC times via generate.
- Arbiter and lock stay in the top module.

Test Plan:
- Reset release, no stimulus -> rvalid 0, lrdy 2'b11, rvc 0.
- NUM_VC=2, DEPTH=4, rrdy 0: write 0x55..0x58 to VC0 -> lrdy[0] 0 after 4th edge, lrdy[1] stays 1. A 5th write to VC0 is dropped. A write 0xA0 to VC1 is accepted.
- Both VCs holding data, rrdy 1 -> rdata alternates VC0/VC1 (0x55, 0xA0, 0x56, ...), rvc toggling.
- VC1 holding 0xA0, rrdy 0 with VC1 granted; write 0x10 to VC0 -> rvc stays 1, rdata 0xA0 until rrdy 1, then 0x10 from VC0.
- Single VC at count 2, write and read on the same edge -> count stays 2, order preserved.
- Assert rst_n low mid-stream -> rvalid 0 and lrdy all 1 without a clock edge. Post-reset reads return only newly written flits.
